alu: RTL and testbench
======================

Name: alu

Overview:
- Registered WIDTH-bit combinational-core ALU with a single-cycle output register. Default width is 4.
- Operations: add, add-with-carry, subtract, AND, OR, XOR, NOT, and complement-then-shift-right.
- Produces a result, a carry-out and a signed-overflow flag.
- Sits in the datapath as the arithmetic/logic execution stage, driven by a decoded 4-bit opcode.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- aluin_a  input  WIDTH  operand A.
- aluin_b  input  WIDTH  operand B.
- opcode  input  4  operation select.
- cin  input  1  carry-in; used only by ADDC.
- alu_out  output  WIDTH  registered result.
- cout  output  1  registered carry/shift-out.
- of  output  1  registered signed overflow.
- zero  output  1  registered result==0 (present only with ALU_ZERO_FLAG_EN).

Behaviour:
- rst_n=0 asynchronously clears alu_out, cout, of and zero to 0. Reset held mid-operation discards any pending result.
- Latency is 1 cycle. The result of inputs sampled at rising edge N is visible after edge N.
- There is no handshake and no enable. Outputs update every cycle.
- Opcode map (a=aluin_a, b=aluin_b), with W=WIDTH:
  - 1000 ADD: {cout,out}=a+b; of=(a[W-1]==b[W-1])&&(out[W-1]!=a[W-1]).
  - 1001 ADDC: {cout,out}=a+b+cin; of computed as for ADD.
  - 1010 SUB: {cout,out}=a+~b+1, so cout=1 means no borrow. cin is ignored. of=(a[W-1]!=b[W-1])&&(out[W-1]!=a[W-1]).
  - 0000 AND: out=a&b.
  - 0001 OR: out=a|b.
  - 0010 XOR: out=a^b.
  - 0100 NOT: out=~a; b is ignored.
  - 0101 NSHR: out={1'b0,(~a)[W-1:1]}, i.e. a logical right shift of ~a. cout=~a[0], the bit shifted out. b is ignored.
  - All other opcodes: out=0.
- Flag rules:
  - Logic ops (AND/OR/XOR/NOT) force cout=0 and of=0.
  - NSHR forces of=0.
  - Undefined opcodes force cout=0 and of=0.
- Arithmetic is modulo 2^W. Carry is taken from a (W+1)-bit internal sum.
- Boundary cases:
  - a=all-ones plus b=1 under ADD gives out=0 and cout=1.
  - 0111+0001 (W=4) gives of=1.
  - SUB with a==b gives out=0 and cout=1.
- X/Z inputs are not required to be handled.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN.
- When defined: port zero exists and is registered alongside alu_out. zero=1 when the next alu_out==0, for every opcode including undefined ones. Reset value is 0.
- When undefined: the zero port and its register are absent. All other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - an opcode enum typedef: OP_AND=4'b0000, OP_OR=4'b0001, OP_XOR=4'b0010, OP_NOT=4'b0100, OP_NSHR=4'b0101, OP_ADD=4'b1000, OP_ADDC=4'b1001, OP_SUB=4'b1010;
  - the default width constant.
- One natural sub-module, alu_adder: a combinational W-bit adder (a, b, cin → sum, cout, of) shared by ADD, ADDC and SUB. For SUB, b is inverted and cin=1.
- Opcode decode and the output register live in alu.

Test Plan:
- Reset: assert rst_n=0 mid-run → alu_out=0000, cout=0, of=0 immediately, without waiting for a clock edge.
- Arithmetic, each result checked one cycle after its inputs are applied:
  - ADD 0110+0011 → 1001, cout=0, of=1.
  - ADDC 0111+0101, cin=1 → 1101, cout=0, of=1.
  - SUB 0111-0101 → 0010, cout=1, of=0.
- Logic, flags all 0:
  - AND 0110,1111 → 0110.
  - OR 0110,0001 → 0111.
  - XOR 0101,1111 → 1010.
  - NOT a=1101 → 0010.
- NSHR a=0101 → 0101, cout=0. NSHR a=0010 → 0110, cout=1.
- Chained computation (a^b)+(~(a&b)>>1) with a=0110, b=0011:
  - XOR → 0101.
  - AND → 0010.
  - NSHR(0010) → 0110.
  - ADD 0101+0110 → 1011, cout=0, of=1.
- Edges and undefined opcodes:
  - ADD 1111+0001 → 0000, cout=1, with zero=1 when ALU_ZERO_FLAG_EN is defined.
  - Opcode 1111 → alu_out=0000, cout=0, of=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encoding and default width for the alu block
//
// Purpose: opcode enum and default operand width used by alu and alu_adder.
// Ports:   none (package).
package alu_pkg;

  localparam int ALU_DEFAULT_WIDTH = 4;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_NOT  = 4'b0100,
    OP_NSHR = 4'b0101,
    OP_ADD  = 4'b1000,
    OP_ADDC = 4'b1001,
    OP_SUB  = 4'b1010
  } alu_op_e;

endpackage

// File: rtl/alu_adder.sv
// rtl/alu_adder.sv - combinational W-bit adder with carry-out and signed overflow
//
// Purpose: shared adder for ADD, ADDC and SUB; the caller pre-inverts b and
//          forces cin=1 for subtraction.
// Ports:
//   i_a, i_b  [W-1:0] operands (i_b already inverted for SUB)
//   i_cin             carry-in
//   o_sum     [W-1:0] sum modulo 2^W
//   o_cout            bit W of the (W+1)-bit internal sum
//   o_of              signed overflow: operands share a sign the sum lacks
module alu_adder
  import alu_pkg::*;
#(
  parameter int W = ALU_DEFAULT_WIDTH
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_of
);

  logic [W:0] w_sum;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
  assign o_sum  = w_sum[W-1:0];
  assign o_cout = w_sum[W];
  // With b pre-inverted for SUB this yields the subtract overflow rule too.
  assign o_of   = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - registered ALU execution stage (one-cycle latency)
//
// Purpose: decodes a 4-bit opcode, computes result/carry/overflow
//          combinationally and registers them every cycle (no enable).
// Optional: ALU_ZERO_FLAG_EN adds a registered zero flag output.
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   aluin_a, aluin_b  [WIDTH-1:0] operands
//   opcode            [3:0] operation select (see alu_pkg::alu_op_e)
//   cin               carry-in, used only by ADDC
//   alu_out           [WIDTH-1:0] registered result
//   cout              registered carry / shifted-out bit
//   of                registered signed overflow
//   zero              registered result==0 (ALU_ZERO_FLAG_EN only)
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] aluin_a,
  input  logic [WIDTH-1:0] aluin_b,
  input  logic [3:0]       opcode,
  input  logic             cin,
  output logic [WIDTH-1:0] alu_out,
  output logic             cout,
  output logic             of
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  logic             w_is_sub;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_cin;
  logic [WIDTH-1:0] w_add_sum;
  logic             w_add_cout;
  logic             w_add_of;
  logic [WIDTH-1:0] w_not_a;
  logic [WIDTH-1:0] w_out;
  logic             w_cout;
  logic             w_of;

  assign w_is_sub  = (opcode == OP_SUB);
  // SUB is a + ~b + 1; ADD ignores cin so ADDC is the only consumer of it.
  assign w_add_b   = w_is_sub ? ~aluin_b : aluin_b;
  assign w_add_cin = w_is_sub ? 1'b1 : ((opcode == OP_ADDC) ? cin : 1'b0);
  assign w_not_a   = ~aluin_a;

  alu_adder #(.W(WIDTH)) u_adder (
    .i_a    (aluin_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout),
    .o_of   (w_add_of)
  );

  always_comb begin
    w_out  = '0;
    w_cout = 1'b0;
    w_of   = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDC, OP_SUB: begin
        w_out  = w_add_sum;
        w_cout = w_add_cout;
        w_of   = w_add_of;
      end
      OP_AND: w_out = aluin_a & aluin_b;
      OP_OR:  w_out = aluin_a | aluin_b;
      OP_XOR: w_out = aluin_a ^ aluin_b;
      OP_NOT: w_out = w_not_a;
      OP_NSHR: begin
        w_out  = {1'b0, w_not_a[WIDTH-1:1]};
        w_cout = w_not_a[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out <= '0;
      cout    <= 1'b0;
      of      <= 1'b0;
    end else begin
      alu_out <= w_out;
      cout    <= w_cout;
      of      <= w_of;
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
    end else begin
      zero <= (w_out == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - table-driven self-checking bench for alu (WIDTH=4)
module tb_alu;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] aluin_a;
  logic [W-1:0] aluin_b;
  logic [3:0]   opcode;
  logic         cin;
  logic [W-1:0] alu_out;
  logic         cout;
  logic         of;
`ifdef ALU_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_checks;
  int n_fail;

  alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .aluin_a (aluin_a),
    .aluin_b (aluin_b),
    .opcode  (opcode),
    .cin     (cin),
    .alu_out (alu_out),
    .cout    (cout),
    .of      (of)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zero    (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [3:0] e_out;
    logic       e_cout;
    logic       e_of;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [3:0] e_out,
                               input logic e_cout, input logic e_of);
    check({name, ".out"},  {4'b0, alu_out}, {4'b0, e_out});
    check({name, ".cout"}, {7'b0, cout},    {7'b0, e_cout});
    check({name, ".of"},   {7'b0, of},      {7'b0, e_of});
`ifdef ALU_ZERO_FLAG_EN
    check({name, ".zero"}, {7'b0, zero},    {7'b0, (e_out == 4'b0)});
`endif
  endtask

  // Drive on the falling edge, then look 1 time unit after the next rising edge.
  task automatic apply(input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic ci);
    @(negedge clk);
    opcode  = op;
    aluin_a = a;
    aluin_b = b;
    cin     = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    opcode   = 4'b1000;
    aluin_a  = 4'b0111;
    aluin_b  = 4'b0111;
    cin      = 1'b0;

    //            name         op       a        b        ci    out      co    of
    vecs.push_back('{"add",    4'b1000, 4'b0110, 4'b0011, 1'b0, 4'b1001, 1'b0, 1'b1});
    vecs.push_back('{"addc",   4'b1001, 4'b0111, 4'b0101, 1'b1, 4'b1101, 1'b0, 1'b1});
    vecs.push_back('{"sub",    4'b1010, 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 1'b0});
    vecs.push_back('{"and",    4'b0000, 4'b0110, 4'b1111, 1'b0, 4'b0110, 1'b0, 1'b0});
    vecs.push_back('{"or",     4'b0001, 4'b0110, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b0});
    vecs.push_back('{"xor",    4'b0010, 4'b0101, 4'b1111, 1'b0, 4'b1010, 1'b0, 1'b0});
    vecs.push_back('{"not",    4'b0100, 4'b1101, 4'b1010, 1'b1, 4'b0010, 1'b0, 1'b0});
    vecs.push_back('{"nshr1",  4'b0101, 4'b0101, 4'b1111, 1'b0, 4'b0101, 1'b0, 1'b0});
    vecs.push_back('{"nshr2",  4'b0101, 4'b0010, 4'b0000, 1'b0, 4'b0110, 1'b1, 1'b0});
    vecs.push_back('{"addwrap",4'b1000, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{"addof",  4'b1000, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1});
    vecs.push_back('{"addcin0",4'b1000, 4'b0111, 4'b0001, 1'b1, 4'b1000, 1'b0, 1'b1});
    vecs.push_back('{"subeq",  4'b1010, 4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{"subbor", 4'b1010, 4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b0, 1'b0});
    vecs.push_back('{"subof",  4'b1010, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b1, 1'b1});
    vecs.push_back('{"addcco", 4'b1001, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0});
    vecs.push_back('{"andz",   4'b0000, 4'b1010, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"undef_f",4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{"undef_3",4'b0011, 4'b0110, 4'b0011, 1'b1, 4'b0000, 1'b0, 1'b0});

    // Reset state, including a clock edge while held.
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_init", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors back-to-back, one per cycle.
    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci);
      check_outputs(vecs[i].name, vecs[i].e_out, vecs[i].e_cout, vecs[i].e_of);
    end

    // Chained (a^b)+(~(a&b)>>1) with a=0110, b=0011; each step feeds the next.
    begin
      logic [3:0] x, y, s;
      apply(4'b0010, 4'b0110, 4'b0011, 1'b0);
      check_outputs("chain_xor", 4'b0101, 1'b0, 1'b0);
      x = alu_out;
      apply(4'b0000, 4'b0110, 4'b0011, 1'b0);
      check_outputs("chain_and", 4'b0010, 1'b0, 1'b0);
      y = alu_out;
      apply(4'b0101, y, 4'b0000, 1'b0);
      check_outputs("chain_nshr", 4'b0110, 1'b1, 1'b0);
      s = alu_out;
      apply(4'b1000, x, s, 1'b0);
      check_outputs("chain_add", 4'b1011, 1'b0, 1'b1);
    end

    // Asynchronous reset mid-run: outputs clear between clock edges.
    apply(4'b1000, 4'b0110, 4'b0011, 1'b0);
    check_outputs("pre_reset", 4'b1001, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("reset_held", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(4'b1010, 4'b0111, 4'b0101, 1'b0);
    check_outputs("post_reset", 4'b0010, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
